ebus_diag_master: RTL and testbench
===================================

Name: ebus_diag_master

Overview:
- Front-end side of the EBUS diagnostic protocol. It is the initiator that the CPU boards' EBUSdrive outputs respond to.
- Accepts one diagnostic-function request at a time from the front-end console logic and sequences EBUS DS/diag-strobe timing.
- On a write, drives data onto the EBUS. On a read, samples the EBUS while checking the board drive-enable vector for no-driver or contention faults.
- Sits between the console/DTE model and the EBUS inside the KL10PV top.

Parameters:
- NDRV, 30: number of board EBUSdrive bits collected into ebus_drive_vec.
- SETUP_CYC, 2: cycles DS/data are stable before diag strobe asserts (range 1-15).
- STROBE_CYC, 3: diag strobe width in cycles; read sample taken on its last cycle (range 1-15).
- HOLD_CYC, 1: cycles DS/data held after strobe deasserts (range 0-15).

Ports:
- clk  in  1  system clock.
- crobar  in  1  asynchronous, active-high reset.
- req_valid  in  1  request offered.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1=diag write, 0=diag read.
- req_func  in  7  diagnostic function code (DS bits).
- req_wdata  in  36  write data.
- rsp_valid  out  1  one-cycle pulse, response available.
- rsp_data  out  36  read data; 0 for writes.
- rsp_nodrv  out  1  read saw zero drivers.
- rsp_multi  out  1  read saw more than one driver.
- ebus_ds  out  7  diagnostic select to boards.
- ebus_diag_strobe  out  1  diag strobe.
- ebus_data_out  out  36  data driven by the front end.
- ebus_data_oe  out  1  front end owns EBUS data.
- ebus_data_in  in  36  resolved EBUS data.
- ebus_drive_vec  in  NDRV  concatenated board EBUSdrive bits.

Behaviour:
- Reset (async, any state): state=IDLE. All outputs are 0, except req_ready=1.
- FSM states: IDLE, SETUP, STROBE, HOLD, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: latch func, write, wdata; load counter=SETUP_CYC-1; go to SETUP.
  - req_ready=0 in every other state; requests there are ignored, not queued.
- SETUP:
  - ebus_ds=latched func.
  - If write: ebus_data_oe=1, ebus_data_out=wdata.
  - When counter reaches 0: load STROBE_CYC-1, go to STROBE.
- STROBE:
  - ebus_diag_strobe=1; DS/data unchanged.
  - On the counter==0 cycle, if read: register rsp_data=ebus_data_in, nodrv=(popcount(vec)==0), multi=(popcount(vec)>1).
  - Then go to HOLD with counter=HOLD_CYC-1, or straight to RESP if HOLD_CYC==0.
- HOLD: strobe=0; DS/data/oe held. When counter reaches 0, go to RESP.
- RESP:
  - ebus_ds=0, oe=0, data_out=0.
  - rsp_valid=1 for exactly this cycle; rsp_data/flags valid in the same cycle.
  - Next state IDLE. No backpressure on the response.
- Read data with multi=1 is still reported as sampled (wired-OR value); nodrv forces rsp_data=0.
- Writes: rsp_data=0, nodrv=0, multi=0, and ebus_drive_vec is ignored.
- Contention guard: ebus_data_oe is never 1 while the state is read-type. If a read sees drive_vec nonzero during SETUP, the guard is satisfied by construction since oe=0.
- Latency from accept to rsp_valid = SETUP_CYC+STROBE_CYC+HOLD_CYC+1 cycles. Defaults give 7.
- rsp_* values other than rsp_valid hold until the next RESP, but are meaningful only with rsp_valid.
- crobar asserted mid-transaction aborts immediately: strobe/oe drop asynchronously and no response is issued.
- req_valid held high through RESP is taken in the following IDLE cycle, giving back-to-back transfers with one idle cycle between them.

Decomposition:
- Shared package ebus_pkg holds:
  - typedef ebus_word_t (36 bits) and ebus_func_t (7 bits);
  - the FSM state enum;
  - named constants for the front-end diagnostic function codes used by tests.
- Sub-module: ebus_drv_check. It is combinational over NDRV bits and outputs none and multiple (popcount 0 vs >1).
- Counters and FSM stay in the top module.

Test Plan:
- Reset: assert crobar for 3 cycles with random inputs -> req_ready=1, all other outputs 0, after and during reset.
- Write: req_write=1, func=7'o071, wdata=36'o123456_654321 ->
  - ebus_ds=071 and oe=1 for 6 cycles;
  - strobe high on cycles 3-5 after accept;
  - rsp_valid on cycle 7 with rsp_data=0.
- Read, single driver: func=7'o100, drive_vec one-hot bit 5, ebus_data_in=36'o777000_000777 during strobe -> rsp_data=36'o777000_000777, nodrv=0, multi=0, oe never 1.
- Read faults:
  - drive_vec=0 -> nodrv=1, rsp_data=0;
  - drive_vec with bits 2 and 17 set -> multi=1, data as sampled.
- Abort and recovery: assert crobar during STROBE -> strobe/oe drop in the same cycle, no rsp_valid; a fresh read afterwards completes in 7 cycles.
- Back-to-back and timing: req_valid held high for two reads -> second accept exactly one cycle after the first rsp_valid. Repeat with SETUP_CYC=1, STROBE_CYC=1, HOLD_CYC=0 -> latency 3.

Source files
------------

// File: rtl/ebus_pkg.sv
// Shared types and constants for the front-end EBUS diagnostic master.
package ebus_pkg;

    typedef logic [35:0] ebus_word_t;
    typedef logic [6:0]  ebus_func_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_RESP   = 3'd4
    } ebus_state_t;

    localparam ebus_func_t FN_WRITE_TEST = 7'o071;
    localparam ebus_func_t FN_READ_TEST  = 7'o100;

endpackage

// File: rtl/ebus_drv_check.sv
// Classifies the board EBUSdrive vector as no driver / more than one driver.
module ebus_drv_check #(
    parameter int NDRV = 30
) (
    input  logic [NDRV-1:0] i_vec,
    output logic            o_none,
    output logic            o_multi
);

    logic [NDRV-1:0] w_low_cleared;

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign w_low_cleared = i_vec & (i_vec - {{(NDRV-1){1'b0}}, 1'b1});
    assign o_none        = ~|i_vec;
    assign o_multi       = |w_low_cleared;

endmodule

// File: rtl/ebus_diag_master.sv
// EBUS diagnostic initiator: sequences DS / diag strobe timing for one
// console request at a time and reports read data with driver-fault flags.
// Handshake: a request is taken on a clock edge where req_valid and req_ready
// are both 1; rsp_valid is a single-cycle pulse with no backpressure.
module ebus_diag_master
    import ebus_pkg::*;
#(
    parameter int NDRV       = 30,
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 3,
    parameter int HOLD_CYC   = 1
) (
    input  logic            clk,
    input  logic            crobar,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [6:0]      req_func,
    input  logic [35:0]     req_wdata,
    output logic            rsp_valid,
    output logic [35:0]     rsp_data,
    output logic            rsp_nodrv,
    output logic            rsp_multi,
    output logic [6:0]      ebus_ds,
    output logic            ebus_diag_strobe,
    output logic [35:0]     ebus_data_out,
    output logic            ebus_data_oe,
    input  logic [35:0]     ebus_data_in,
    input  logic [NDRV-1:0] ebus_drive_vec,
    output logic [2:0]      dbg_state
);

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = (HOLD_CYC == 0) ? 4'd0 : 4'(HOLD_CYC - 1);
    localparam bit         HAS_HOLD  = (HOLD_CYC != 0);

    ebus_state_t r_state;
    logic [3:0]  r_cnt;
    logic        r_write;
    ebus_word_t  r_samp_data;
    logic        r_samp_nodrv, r_samp_multi;
    logic        r_req_ready, r_rsp_valid, r_rsp_nodrv, r_rsp_multi;
    ebus_word_t  r_rsp_data, r_dout;
    ebus_func_t  r_ds;
    logic        r_strobe, r_oe;

    logic        w_none, w_multi, w_sample, w_enter_resp;
    ebus_word_t  w_samp_data;

    ebus_drv_check #(.NDRV(NDRV)) u_drv_check (
        .i_vec   (ebus_drive_vec),
        .o_none  (w_none),
        .o_multi (w_multi)
    );

    assign w_sample     = (r_state == ST_STROBE) && (r_cnt == 4'd0) && !r_write;
    assign w_samp_data  = w_none ? '0 : ebus_data_in;
    assign w_enter_resp = ((r_state == ST_STROBE) && (r_cnt == 4'd0) && !HAS_HOLD) ||
                          ((r_state == ST_HOLD) && (r_cnt == 4'd0));

    always_ff @(posedge clk or posedge crobar) begin
        if (crobar) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 4'd0;
            r_write      <= 1'b0;
            r_samp_data  <= '0;
            r_samp_nodrv <= 1'b0;
            r_samp_multi <= 1'b0;
            r_req_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_nodrv  <= 1'b0;
            r_rsp_multi  <= 1'b0;
            r_ds         <= '0;
            r_strobe     <= 1'b0;
            r_dout       <= '0;
            r_oe         <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_state      <= ST_SETUP;
                        r_cnt        <= SETUP_LD;
                        r_req_ready  <= 1'b0;
                        r_write      <= req_write;
                        r_ds         <= req_func;
                        r_oe         <= req_write;
                        r_dout       <= req_write ? req_wdata : '0;
                        r_samp_data  <= '0;
                        r_samp_nodrv <= 1'b0;
                        r_samp_multi <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    if (r_cnt == 4'd0) begin
                        r_state  <= ST_STROBE;
                        r_cnt    <= STROBE_LD;
                        r_strobe <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_STROBE: begin
                    if (r_cnt == 4'd0) begin
                        r_strobe <= 1'b0;
                        if (w_sample) begin
                            r_samp_data  <= w_samp_data;
                            r_samp_nodrv <= w_none;
                            r_samp_multi <= w_multi;
                        end
                        if (HAS_HOLD) begin
                            r_state <= ST_HOLD;
                            r_cnt   <= HOLD_LD;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                end
                ST_RESP: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
            // Entry into RESP may come from STROBE or HOLD; the sample may be this very edge.
            if (w_enter_resp) begin
                r_state     <= ST_RESP;
                r_ds        <= '0;
                r_oe        <= 1'b0;
                r_dout      <= '0;
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= w_sample ? w_samp_data : r_samp_data;
                r_rsp_nodrv <= w_sample ? w_none      : r_samp_nodrv;
                r_rsp_multi <= w_sample ? w_multi     : r_samp_multi;
            end
        end
    end

    assign req_ready        = r_req_ready;
    assign rsp_valid        = r_rsp_valid;
    assign rsp_data         = r_rsp_data;
    assign rsp_nodrv        = r_rsp_nodrv;
    assign rsp_multi        = r_rsp_multi;
    assign ebus_ds          = r_ds;
    assign ebus_diag_strobe = r_strobe;
    assign ebus_data_out    = r_dout;
    assign ebus_data_oe     = r_oe;
    assign dbg_state        = r_state;

endmodule

// File: tb/tb_ebus_diag_master.sv
// Bench for ebus_diag_master: default timing instance plus a 1/1/0 timing instance.
module tb_ebus_diag_master;
  import ebus_pkg::*;

  logic        clk = 1'b0;
  logic        crobar = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [6:0]  req_func = '0;
  logic [35:0] req_wdata = '0;
  logic [35:0] ebus_data_in = '0;
  logic [29:0] ebus_drive_vec = '0;
  logic        use_fast = 1'b0;

  logic        d_ready, d_rv, d_nodrv, d_multi, d_strobe, d_oe;
  logic [35:0] d_rdata, d_dout;
  logic [6:0]  d_ds;
  logic [2:0]  d_state;
  logic        f_ready, f_rv, f_nodrv, f_multi, f_strobe, f_oe;
  logic [35:0] f_rdata, f_dout;
  logic [6:0]  f_ds;
  logic [2:0]  f_state;

  logic        m_ready, m_rv, m_nodrv, m_multi, m_strobe, m_oe;
  logic [35:0] m_rdata, m_dout;
  logic [6:0]  m_ds;
  logic [2:0]  m_state;

  logic [37:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ebus_diag_master dut (
    .clk(clk), .crobar(crobar), .req_valid(req_valid & ~use_fast), .req_ready(d_ready),
    .req_write(req_write), .req_func(req_func), .req_wdata(req_wdata),
    .rsp_valid(d_rv), .rsp_data(d_rdata), .rsp_nodrv(d_nodrv), .rsp_multi(d_multi),
    .ebus_ds(d_ds), .ebus_diag_strobe(d_strobe), .ebus_data_out(d_dout), .ebus_data_oe(d_oe),
    .ebus_data_in(ebus_data_in), .ebus_drive_vec(ebus_drive_vec), .dbg_state(d_state)
  );

  ebus_diag_master #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(0)) dut_f (
    .clk(clk), .crobar(crobar), .req_valid(req_valid & use_fast), .req_ready(f_ready),
    .req_write(req_write), .req_func(req_func), .req_wdata(req_wdata),
    .rsp_valid(f_rv), .rsp_data(f_rdata), .rsp_nodrv(f_nodrv), .rsp_multi(f_multi),
    .ebus_ds(f_ds), .ebus_diag_strobe(f_strobe), .ebus_data_out(f_dout), .ebus_data_oe(f_oe),
    .ebus_data_in(ebus_data_in), .ebus_drive_vec(ebus_drive_vec), .dbg_state(f_state)
  );

  always_comb begin
    m_ready = use_fast ? f_ready : d_ready;
    m_rv = use_fast ? f_rv : d_rv;
    m_rdata = use_fast ? f_rdata : d_rdata;
    m_nodrv = use_fast ? f_nodrv : d_nodrv;
    m_multi = use_fast ? f_multi : d_multi;
    m_ds = use_fast ? f_ds : d_ds;
    m_strobe = use_fast ? f_strobe : d_strobe;
    m_dout = use_fast ? f_dout : d_dout;
    m_oe = use_fast ? f_oe : d_oe;
    m_state = use_fast ? f_state : d_state;
  end

  function automatic logic [37:0] expect_rsp(input logic wr, input logic [29:0] vec,
                                             input logic [35:0] din);
    if (wr) return 38'd0;
    if (vec == 30'd0) return {1'b1, 1'b0, 36'd0};
    return {1'b0, ($countones(vec) > 1), din};
  endfunction

  task automatic test_reset();
    logic [87:0] got;
    crobar = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      req_valid = 1'($urandom_range(0, 1));
      req_write = 1'($urandom_range(0, 1));
      req_func = 7'($urandom_range(0, 127));
      req_wdata = {4'($urandom_range(0, 15)), 32'($urandom())};
      ebus_data_in = {4'($urandom_range(0, 15)), 32'($urandom())};
      ebus_drive_vec = 30'($urandom());
      if (c == 3) begin
        crobar = 1'b0;
        req_valid = 1'b0;
      end
      got = {m_ready, m_rv, m_rdata, m_nodrv, m_multi, m_ds, m_strobe, m_dout, m_oe, m_state};
      n_cmp++;
      if (got !== {1'b1, 87'd0}) begin
        n_err++;
        $display("FAIL reset_outputs cycle=%0d got=%h exp=%h", c, got, {1'b1, 87'd0});
      end
    end
    @(negedge clk);
    got = {m_ready, m_rv, m_rdata, m_nodrv, m_multi, m_ds, m_strobe, m_dout, m_oe, m_state};
    n_cmp++;
    if (got !== {1'b1, 87'd0}) begin
      n_err++;
      $display("FAIL post_reset_outputs got=%h exp=%h", got, {1'b1, 87'd0});
    end
  endtask

  task automatic do_txn(input logic wr, input logic [6:0] fn, input logic [35:0] wd,
                        input logic [29:0] vec, input logic [35:0] din);
    int s, t, h, lat;
    logic [37:0] exp_v, got;
    bit seen;
    s = use_fast ? 1 : 2;
    t = use_fast ? 1 : 3;
    h = use_fast ? 0 : 1;
    lat = s + t + h + 1;
    seen = 0;
    @(negedge clk);
    n_cmp++;
    if (m_ready !== 1'b1) begin
      n_err++;
      $display("FAIL txn_ready_idle got=%b exp=1", m_ready);
    end
    req_valid = 1'b1;
    req_write = wr;
    req_func = fn;
    req_wdata = wd;
    ebus_drive_vec = vec;
    ebus_data_in = din;
    exp_q.push_back(expect_rsp(wr, vec, din));
    for (int k = 1; k <= lat + 2; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      n_cmp++;
      if (m_ds !== ((k < lat) ? fn : 7'd0)) begin
        n_err++;
        $display("FAIL txn_ds k=%0d got=%o exp=%o", k, m_ds, (k < lat) ? fn : 7'd0);
      end
      n_cmp++;
      if (m_oe !== (wr && (k < lat))) begin
        n_err++;
        $display("FAIL txn_oe k=%0d got=%b exp=%b", k, m_oe, wr && (k < lat));
      end
      n_cmp++;
      if (m_dout !== ((wr && (k < lat)) ? wd : 36'd0)) begin
        n_err++;
        $display("FAIL txn_data_out k=%0d got=%o", k, m_dout);
      end
      n_cmp++;
      if (m_strobe !== ((k > s) && (k <= s + t))) begin
        n_err++;
        $display("FAIL txn_strobe k=%0d got=%b exp=%b", k, m_strobe, (k > s) && (k <= s + t));
      end
      n_cmp++;
      if (m_rv !== (k == lat)) begin
        n_err++;
        $display("FAIL txn_rsp_valid k=%0d got=%b exp=%b", k, m_rv, k == lat);
      end
      if (m_rv === 1'b1) begin
        seen = 1;
        got = {m_nodrv, m_multi, m_rdata};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL txn_unexpected_rsp got=%h exp=none", got);
        end else begin
          exp_v = exp_q.pop_front();
          if (got !== exp_v) begin
            n_err++;
            $display("FAIL txn_rsp {nodrv,multi,data} got=%h exp=%h", got, exp_v);
          end
        end
      end
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL txn_timeout no rsp_valid within %0d cycles got=0 exp=1", lat + 2);
      exp_q.delete();
    end
  endtask

  task automatic test_write();
    do_txn(1'b1, FN_WRITE_TEST, 36'o123456_654321, 30'($urandom()),
           {4'($urandom_range(0, 15)), 32'($urandom())});
  endtask

  task automatic test_read_single();
    do_txn(1'b0, FN_READ_TEST, 36'd0, 30'd1 << 5, 36'o777000_000777);
  endtask

  task automatic test_read_faults();
    do_txn(1'b0, FN_READ_TEST, 36'd0, 30'd0, 36'o525252_252525);
    do_txn(1'b0, FN_READ_TEST, 36'd0, (30'd1 << 2) | (30'd1 << 17), 36'o707070_070707);
    for (int i = 0; i < 3; i++)
      do_txn(1'b0, 7'($urandom_range(0, 127)), 36'd0, 30'd1 << $urandom_range(0, 29),
             {4'($urandom_range(0, 15)), 32'($urandom())});
  endtask

  task automatic test_abort();
    logic seen_rv;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_func = FN_WRITE_TEST;
    req_wdata = 36'o111111_222222;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    n_cmp++;
    if ({m_strobe, m_oe} !== 2'b11) begin
      n_err++;
      $display("FAIL abort_pre_strobe {strobe,oe} got=%b exp=11", {m_strobe, m_oe});
    end
    crobar = 1'b1;
    #1;
    n_cmp++;
    if ({m_strobe, m_oe, m_rv, m_ready} !== 4'b0001) begin
      n_err++;
      $display("FAIL abort_drop {strobe,oe,rsp_valid,ready} got=%b exp=0001",
               {m_strobe, m_oe, m_rv, m_ready});
    end
    @(negedge clk);
    @(negedge clk);
    crobar = 1'b0;
    seen_rv = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (m_rv === 1'b1) seen_rv = 1'b1;
    end
    n_cmp++;
    if (seen_rv !== 1'b0) begin
      n_err++;
      $display("FAIL abort_no_rsp got=%b exp=0", seen_rv);
    end
    do_txn(1'b0, FN_READ_TEST, 36'd0, 30'd1 << 11, 36'o123123_321321);
  endtask

  task automatic test_back_to_back();
    int lat, n_acc, acc1, acc2, rsp1, rsp2, n_rsp;
    logic [37:0] exp_v, got;
    lat = use_fast ? 3 : 7;
    n_acc = 0; n_rsp = 0;
    acc1 = -1; acc2 = -1; rsp1 = -1; rsp2 = -1;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_func = FN_READ_TEST;
    ebus_drive_vec = 30'd1 << 9;
    ebus_data_in = {4'($urandom_range(0, 15)), 32'($urandom())};
    for (int i = 0; i < 40 && n_rsp < 2; i++) begin
      if (m_rv === 1'b1) begin
        got = {m_nodrv, m_multi, m_rdata};
        n_rsp++;
        if (n_rsp == 1) rsp1 = i; else rsp2 = i;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL b2b_unexpected_rsp got=%h exp=none", got);
        end else begin
          exp_v = exp_q.pop_front();
          if (got !== exp_v) begin
            n_err++;
            $display("FAIL b2b_rsp got=%h exp=%h", got, exp_v);
          end
        end
      end
      if (n_acc == 2) req_valid = 1'b0;
      if (req_valid && m_ready === 1'b1) begin
        n_acc++;
        if (n_acc == 1) acc1 = i; else acc2 = i;
        exp_q.push_back(expect_rsp(1'b0, ebus_drive_vec, ebus_data_in));
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    n_cmp++;
    if (rsp1 - acc1 !== lat || rsp2 - acc2 !== lat || n_rsp !== 2) begin
      n_err++;
      $display("FAIL b2b_latency got=%0d,%0d (rsps=%0d) exp=%0d", rsp1 - acc1, rsp2 - acc2,
               n_rsp, lat);
    end
    n_cmp++;
    if (acc2 - rsp1 !== 1) begin
      n_err++;
      $display("FAIL b2b_second_accept got=%0d exp=1", acc2 - rsp1);
    end
    exp_q.delete();
  endtask

  task automatic test_fast();
    use_fast = 1'b1;
    do_txn(1'b0, FN_READ_TEST, 36'd0, 30'd1 << 29, 36'o654321_123456);
    do_txn(1'b1, FN_WRITE_TEST, 36'o000777_777000, 30'd0, 36'd0);
    do_txn(1'b0, FN_READ_TEST, 36'd0, 30'd0, 36'o777777_777777);
    test_back_to_back();
    use_fast = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_single();
    test_read_faults();
    test_abort();
    test_back_to_back();
    test_fast();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
